// File: rtl/gol_gen_ctrl.sv
// gol_gen_ctrl: generation sequencer for the 8x8 Game of Life datapath with display handshake.
// Optional build macro GOL_STILL_HALT_EN adds a HALT state entered once a still life is reached.
module gol_gen_ctrl #(
   parameter int GRID_W    = 64,
   parameter int TICK_DIV  = 4,
   parameter int GEN_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [GRID_W-1:0]    seed,
   input  logic                 load,
   input  logic                 run,
   input  logic                 step,
   input  logic [GRID_W-1:0]    next_grid,
   output logic [GRID_W-1:0]    cur_grid,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [GEN_CNT_W-1:0] gen_count,
   output logic                 extinct,
   output logic                 busy,
   output logic                 stable
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      PRESENT,
      WAIT_TICK,
      COMPUTE,
`ifdef GOL_STILL_HALT_EN
      COMMIT,
      HALT
`else
      COMMIT
`endif
   } state_t;

   state_t        state;
   logic [TW-1:0] tick;

   assign extinct = (cur_grid == '0);
   assign busy    = (state != IDLE);

`ifndef GOL_STILL_HALT_EN
   assign stable = 1'b0;
`endif

   // Sequencer: load overrides everything, otherwise walk present/wait/compute/commit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cur_grid    <= '0;
         frame_valid <= 1'b0;
         gen_count   <= '0;
         tick        <= '0;
`ifdef GOL_STILL_HALT_EN
         stable      <= 1'b0;
`endif
      end else if (load) begin
         state       <= PRESENT;
         cur_grid    <= seed;
         frame_valid <= 1'b1;
         gen_count   <= '0;
         tick        <= '0;
`ifdef GOL_STILL_HALT_EN
         stable      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tick  <= '0;
               state <= run ? WAIT_TICK : (step ? COMPUTE : IDLE);
            end
            PRESENT: begin
               tick <= '0;
               if (frame_ready) begin
                  frame_valid <= 1'b0;
`ifdef GOL_STILL_HALT_EN
                  state <= stable ? HALT : (run ? WAIT_TICK : IDLE);
`else
                  state <= run ? WAIT_TICK : IDLE;
`endif
               end
            end
            WAIT_TICK: begin
               if (!run) begin
                  tick  <= '0;
                  state <= IDLE;
               end else if (tick == TW'(TICK_DIV - 1)) begin
                  tick  <= '0;
                  state <= COMPUTE;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            COMPUTE: state <= COMMIT;
            COMMIT: begin
               cur_grid    <= next_grid;
               gen_count   <= gen_count + 1'b1;
               frame_valid <= 1'b1;
               state       <= PRESENT;
`ifdef GOL_STILL_HALT_EN
               stable      <= (next_grid == cur_grid);
`endif
            end
`ifdef GOL_STILL_HALT_EN
            HALT: state <= HALT;
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gol_gen_ctrl.sv
// tb_gol_gen_ctrl: directed and randomized checks of gol_gen_ctrl against a Game of Life reference.
module tb_gol_gen_ctrl;
   localparam logic [63:0] GLIDER  = 64'h4020_E000_0000_0000;
   localparam logic [63:0] BLINKER = 64'h000E_0000_0000_0000;
   localparam logic [63:0] BLINK_V = 64'h0404_0400_0000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [63:0] seed = '0;
   logic        load = 1'b0, run = 1'b0, step = 1'b0, frame_ready = 1'b0;
   logic [63:0] next_grid, cur_grid;
   logic        frame_valid, extinct, busy, stable;
   logic [15:0] gen_count;

   int n_cmp = 0;
   int n_err = 0;

   gol_gen_ctrl #(.GRID_W(64), .TICK_DIV(4), .GEN_CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .seed(seed), .load(load), .run(run), .step(step),
      .next_grid(next_grid), .cur_grid(cur_grid), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .gen_count(gen_count), .extinct(extinct),
      .busy(busy), .stable(stable)
   );

   always #5 clk = ~clk;

   // Reference datapath: one Life generation, cells outside the 8x8 grid are dead.
   function automatic logic [63:0] life(input logic [63:0] g);
      logic [63:0] n;
      n = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            int cnt;
            logic alive;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                     cnt += int'(g[63 - ((r + dr) * 8 + c + dc)]);
            alive = g[63 - (r * 8 + c)];
            n[63 - (r * 8 + c)] = (cnt == 3) || (alive && cnt == 2);
         end
      return n;
   endfunction

   assign next_grid = life(cur_grid);

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic do_load(input logic [63:0] s);
      seed = s;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] g, last_grid;
      logic [15:0] last_gen;
      logic        acc;
      int          t_commit[$];
      int          k;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_grid", cur_grid, 64'd0);
      chk("rst_fv", 64'(frame_valid), 64'd0);
      chk("rst_gen", 64'(gen_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stable", 64'(stable), 64'd0);
      chk("rst_extinct", 64'(extinct), 64'd1);
      rstn = 1'b1;
      @(negedge clk);

      // Glider load with display ready: frame valid for exactly one cycle
      frame_ready = 1'b1;
      do_load(GLIDER);
      chk("ld_grid", cur_grid, GLIDER);
      chk("ld_fv", 64'(frame_valid), 64'd1);
      chk("ld_gen", 64'(gen_count), 64'd0);
      chk("ld_extinct", 64'(extinct), 64'd0);
      @(negedge clk);
      chk("ld_fv_drop", 64'(frame_valid), 64'd0);
      chk("ld_idle", 64'(busy), 64'd0);

      // Blinker single-step: result on third edge after the pulse
      do_load(BLINKER);
      @(negedge clk);
      for (int n = 1; n <= 2; n++) begin
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         @(negedge clk);
         chk("step_e2_grid", cur_grid, (n == 1) ? BLINKER : BLINK_V);
         chk("step_e2_fv", 64'(frame_valid), 64'd0);
         @(negedge clk);
         chk("step_e3_grid", cur_grid, (n == 1) ? BLINK_V : BLINKER);
         chk("step_e3_fv", 64'(frame_valid), 64'd1);
         chk("step_gen", 64'(gen_count), 64'(n));
         @(negedge clk);
         chk("step_idle", 64'(busy), 64'd0);
      end

      // Free run: commit every TICK_DIV+3 = 7 cycles with ready held high
      last_grid = cur_grid;
      last_gen = gen_count;
      run = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (gen_count != last_gen) begin
            t_commit.push_back(i);
            chk("run_grid", cur_grid, life(last_grid));
            chk("run_gen", 64'(gen_count), 64'(last_gen + 16'd1));
            last_grid = cur_grid;
            last_gen = gen_count;
         end
      end
      chk("run_ncommit", 64'(t_commit.size()), 64'd4);
      if (t_commit.size() > 0) chk("run_first", 64'(t_commit[0]), 64'd7);
      for (int i = 1; i < t_commit.size(); i++)
         chk("run_period", 64'(t_commit[i] - t_commit[i-1]), 64'd7);

      // Backpressure: frame held, no commit while unaccepted
      k = 0;
      while (!frame_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("bp_fv_seen", 64'(frame_valid), 64'd1);
      g = cur_grid;
      last_gen = gen_count;
      frame_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_grid", cur_grid, g);
         chk("bp_gen", 64'(gen_count), 64'(last_gen));
         chk("bp_fv", 64'(frame_valid), 64'd1);
      end
      frame_ready = 1'b1;
      run = 1'b0;
      wait_idle();

      // run dropped during tick wait returns to IDLE without a commit
      last_gen = gen_count;
      run = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("rundrop_idle", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      chk("rundrop_gen", 64'(gen_count), 64'(last_gen));

      // Simultaneous load and step: seed wins, no generation computed
      step = 1'b1;
      do_load(GLIDER);
      step = 1'b0;
      chk("ldstep_grid", cur_grid, GLIDER);
      chk("ldstep_gen", 64'(gen_count), 64'd0);
      repeat (5) @(negedge clk);
      chk("ldstep_grid2", cur_grid, GLIDER);
      chk("ldstep_gen2", 64'(gen_count), 64'd0);

      // Extinct grid keeps iterating
      do_load(64'd0);
      chk("ext_flag", 64'(extinct), 64'd1);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      chk("ext_gen", 64'(gen_count), 64'd1);
      chk("ext_grid", cur_grid, 64'd0);
      wait_idle();

      // Randomized free runs with random display backpressure
      for (int r = 0; r < 4; r++) begin
         g = {$urandom, $urandom} & {$urandom, $urandom};
         run = 1'b1;
         do_load(g);
         chk("rnd_seed", cur_grid, g);
         last_grid = g;
         last_gen = 16'd0;
         acc = 1'b0;
         for (int i = 0; i < 150; i++) begin
            frame_ready = ($urandom_range(0, 3) != 0);
            acc = acc | (frame_valid & frame_ready);
            @(negedge clk);
            if (gen_count != last_gen) begin
               chk("rnd_gen", 64'(gen_count), 64'(last_gen + 16'd1));
               chk("rnd_nodrop", 64'(acc), 64'd1);
               chk("rnd_grid", cur_grid, life(last_grid));
               last_grid = cur_grid;
               last_gen = gen_count;
               acc = 1'b0;
            end else begin
               chk("rnd_hold", cur_grid, last_grid);
            end
         end
         run = 1'b0;
         frame_ready = 1'b1;
         wait_idle();
      end

      // Asynchronous reset in the middle of COMMIT
      do_load(BLINKER);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("arst_grid", cur_grid, 64'd0);
      chk("arst_fv", 64'(frame_valid), 64'd0);
      chk("arst_gen", 64'(gen_count), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_stay", cur_grid, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
